// File: rtl/rx_burst_gate.sv
// Burst gate: forwards I/Q samples only while a signal-detect burst is open, and reports each burst's length.
// Optional pre-trigger delay line enabled by defining RX_BG_PRETRIGGER_EN.
module rx_burst_gate #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PRE_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  RX_BG_ARM,
  input  logic [7:0]                  RX_BG_HANG,
  input  logic [CNT_WIDTH-1:0]        RX_BG_MAXLEN,
  input  logic                        SD_flag,
  input  logic signed [WIDTH-1:0]     I_tdata,
  input  logic signed [WIDTH-1:0]     Q_tdata,
  input  logic                        I_tvalid,
  input  logic                        Q_tvalid,
  output logic signed [WIDTH-1:0]     I_out,
  output logic signed [WIDTH-1:0]     Q_out,
  output logic                        out_tvalid,
  output logic                        burst_active,
  output logic                        burst_start,
  output logic                        burst_end,
  output logic [CNT_WIDTH-1:0]        burst_len,
  output logic                        burst_trunc
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_ACTIVE  = 3'd2;
  localparam logic [2:0] S_HANG    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  if (PRE_DEPTH < 1) begin : g_bad_depth
    $error("PRE_DEPTH must be at least 1");
  end

  logic [2:0]           state, state_nxt;
  logic [7:0]           arm_cnt, arm_cnt_nxt;
  logic [7:0]           hang_cnt, hang_cnt_nxt;
  logic [CNT_WIDTH-1:0] len_cnt, len_nxt;
  logic [7:0]           arm_q, hang_q;
  logic [CNT_WIDTH-1:0] max_q;
  logic                 sample_valid, in_burst, fwd, trunc_hit;
  logic                 enter, close, latch_cfg;
  logic                 close_pend, trunc_pend;
  logic signed [WIDTH-1:0] fwd_i, fwd_q;

  assign sample_valid = I_tvalid & Q_tvalid;
  assign in_burst     = (state == S_ACTIVE) || (state == S_HANG);
  assign fwd          = in_burst && sample_valid && (len_cnt < max_q);
  assign len_nxt      = len_cnt + CNT_WIDTH'(fwd);
  assign trunc_hit    = in_burst && (len_nxt >= max_q);

`ifdef RX_BG_PRETRIGGER_EN
  // Sample history runs in every state so a new burst carries its lead-in.
  logic signed [WIDTH-1:0] dl_i [PRE_DEPTH];
  logic signed [WIDTH-1:0] dl_q [PRE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PRE_DEPTH; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
    end else if (sample_valid) begin
      dl_i[0] <= I_tdata;
      dl_q[0] <= Q_tdata;
      for (int unsigned k = 1; k < PRE_DEPTH; k++) begin
        dl_i[k] <= dl_i[k-1];
        dl_q[k] <= dl_q[k-1];
      end
    end
  end

  assign fwd_i = dl_i[PRE_DEPTH-1];
  assign fwd_q = dl_q[PRE_DEPTH-1];
`else
  assign fwd_i = I_tdata;
  assign fwd_q = Q_tdata;
`endif

  // Next-state logic; truncation has priority over hang expiry and SD changes.
  always_comb begin
    state_nxt    = state;
    arm_cnt_nxt  = arm_cnt;
    hang_cnt_nxt = hang_cnt;
    enter        = 1'b0;
    close        = 1'b0;
    latch_cfg    = 1'b0;
    case (state)
      S_IDLE: begin
        if (SD_flag) begin
          latch_cfg = 1'b1;
          if (RX_BG_ARM <= 8'd1) begin
            state_nxt = S_ACTIVE;
            enter     = 1'b1;
          end else begin
            state_nxt   = S_ARM;
            arm_cnt_nxt = 8'd1;
          end
        end
      end
      S_ARM: begin
        if (!SD_flag) begin
          state_nxt   = S_IDLE;
          arm_cnt_nxt = 8'd0;
        end else if (arm_cnt + 8'd1 >= arm_q) begin
          state_nxt = S_ACTIVE;
          enter     = 1'b1;
        end else begin
          arm_cnt_nxt = arm_cnt + 8'd1;
        end
      end
      S_ACTIVE: begin
        if (trunc_hit) begin
          state_nxt = S_LOCKOUT;
          close     = 1'b1;
        end else if (!SD_flag) begin
          hang_cnt_nxt = 8'd0;
          if (hang_q == 8'd0) begin
            state_nxt = S_IDLE;
            close     = 1'b1;
          end else begin
            state_nxt = S_HANG;
          end
        end
      end
      S_HANG: begin
        if (trunc_hit) begin
          state_nxt = S_LOCKOUT;
          close     = 1'b1;
        end else if (SD_flag) begin
          state_nxt = S_ACTIVE;
        end else if (hang_cnt + 8'd1 >= hang_q) begin
          state_nxt = S_IDLE;
          close     = 1'b1;
        end else begin
          hang_cnt_nxt = hang_cnt + 8'd1;
        end
      end
      S_LOCKOUT: begin
        if (!SD_flag) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      arm_cnt  <= '0;
      hang_cnt <= '0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= arm_cnt_nxt;
      hang_cnt <= hang_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q   <= '0;
      hang_q  <= '0;
      max_q   <= '0;
      len_cnt <= '0;
    end else begin
      if (latch_cfg) begin
        arm_q  <= RX_BG_ARM;
        hang_q <= RX_BG_HANG;
        max_q  <= RX_BG_MAXLEN;
      end
      if (enter)    len_cnt <= '0;
      else if (fwd) len_cnt <= len_nxt;
    end
  end

  // Burst report trails the close decision by two edges so it lands after the last forwarded sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      I_out        <= '0;
      Q_out        <= '0;
      out_tvalid   <= 1'b0;
      burst_active <= 1'b0;
      burst_start  <= 1'b0;
      burst_end    <= 1'b0;
      burst_len    <= '0;
      burst_trunc  <= 1'b0;
      close_pend   <= 1'b0;
      trunc_pend   <= 1'b0;
    end else begin
      out_tvalid   <= fwd;
      if (fwd) begin
        I_out <= fwd_i;
        Q_out <= fwd_q;
      end
      burst_active <= (state_nxt == S_ACTIVE) || (state_nxt == S_HANG);
      burst_start  <= enter;
      close_pend   <= close;
      trunc_pend   <= close & trunc_hit;
      burst_end    <= close_pend;
      if (close_pend) begin
        burst_len   <= len_cnt;
        burst_trunc <= trunc_pend;
      end
    end
  end

endmodule

// File: tb/tb_rx_burst_gate.sv
// Directed bench for rx_burst_gate with a cycle-level reference model of the burst rules.
module tb_rx_burst_gate;

  localparam int unsigned PRE = 8;
  localparam int P_IDLE = 0, P_ARMING = 1, P_BURST = 2, P_LOCK = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] RX_BG_ARM, RX_BG_HANG;
  logic [15:0] RX_BG_MAXLEN;
  logic SD_flag, I_tvalid, Q_tvalid;
  logic signed [15:0] I_tdata, Q_tdata;
  logic signed [15:0] I_out, Q_out;
  logic out_tvalid, burst_active, burst_start, burst_end, burst_trunc;
  logic [15:0] burst_len;

  rx_burst_gate dut (
    .clk(clk), .rst_n(rst_n),
    .RX_BG_ARM(RX_BG_ARM), .RX_BG_HANG(RX_BG_HANG), .RX_BG_MAXLEN(RX_BG_MAXLEN),
    .SD_flag(SD_flag),
    .I_tdata(I_tdata), .Q_tdata(Q_tdata), .I_tvalid(I_tvalid), .Q_tvalid(Q_tvalid),
    .I_out(I_out), .Q_out(Q_out), .out_tvalid(out_tvalid),
    .burst_active(burst_active), .burst_start(burst_start), .burst_end(burst_end),
    .burst_len(burst_len), .burst_trunc(burst_trunc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int m_phase = P_IDLE;
  int high_run, low_run, fwd_n, arm_l, hang_l, max_l;
  logic signed [15:0] hist_i[$];
  logic signed [15:0] hist_q[$];
  logic e_valid, e_active, e_start, e_end, e_trunc, p_end, p_trunc;
  logic signed [15:0] e_i, e_q;
  int e_len, p_len;

  // Observation counters
  int k = 0;
  int cnt_start = 0, cnt_end = 0, cnt_valid = 0;
  int k_rise, k_start, k_end, k_valid;
  logic prev_sd = 1'b0;
  logic first_pend = 1'b0;
  logic signed [15:0] in_at_start, first_out;

  task automatic model_reset();
    m_phase = P_IDLE;
    high_run = 0; low_run = 0; fwd_n = 0;
    hist_i.delete(); hist_q.delete();
    e_valid = 0; e_active = 0; e_start = 0; e_end = 0; e_trunc = 0;
    e_i = 0; e_q = 0; e_len = 0;
    p_end = 0; p_len = 0; p_trunc = 0;
  endtask

  // One model step: inputs now visible are consumed at the next rising edge.
  task automatic model_step();
    logic sv, nv, ns, cl, tr;
    logic signed [15:0] di, dq;
    sv = I_tvalid && Q_tvalid;
    nv = 0; ns = 0; cl = 0; tr = 0;
    di = I_tdata; dq = Q_tdata;
`ifdef RX_BG_PRETRIGGER_EN
    di = (hist_i.size() >= PRE) ? hist_i[hist_i.size() - PRE] : 16'sd0;
    dq = (hist_q.size() >= PRE) ? hist_q[hist_q.size() - PRE] : 16'sd0;
    if (sv) begin
      hist_i.push_back(I_tdata);
      hist_q.push_back(Q_tdata);
      if (hist_i.size() > PRE) begin
        void'(hist_i.pop_front());
        void'(hist_q.pop_front());
      end
    end
`endif
    case (m_phase)
      P_IDLE: if (SD_flag) begin
        arm_l = int'(RX_BG_ARM); hang_l = int'(RX_BG_HANG); max_l = int'(RX_BG_MAXLEN);
        high_run = 1;
        if (arm_l <= 1) begin m_phase = P_BURST; ns = 1; fwd_n = 0; low_run = 0; end
        else m_phase = P_ARMING;
      end
      P_ARMING: begin
        if (!SD_flag) m_phase = P_IDLE;
        else begin
          high_run++;
          if (high_run >= arm_l) begin m_phase = P_BURST; ns = 1; fwd_n = 0; low_run = 0; end
        end
      end
      P_BURST: begin
        if (sv && fwd_n < max_l) begin nv = 1; fwd_n++; end
        if (fwd_n >= max_l) begin cl = 1; tr = 1; m_phase = P_LOCK; end
        else if (SD_flag) low_run = 0;
        else begin
          low_run++;
          if (low_run > hang_l) begin cl = 1; m_phase = P_IDLE; end
        end
      end
      default: if (!SD_flag) m_phase = P_IDLE;
    endcase
    e_valid = nv;
    if (nv) begin e_i = di; e_q = dq; end
    e_start = ns;
    e_active = (m_phase == P_BURST);
    e_end = p_end;
    if (p_end) begin e_len = p_len; e_trunc = p_trunc; end
    p_end = cl; p_len = fwd_n; p_trunc = tr;
  endtask

  // Single compare process
  always @(negedge clk) begin
    k++;
    if (!rst_n) begin
      model_reset();
      prev_sd = 1'b0;
      first_pend = 1'b0;
      chk("rst_out_tvalid", out_tvalid, 0);
      chk("rst_active", burst_active, 0);
      chk("rst_start", burst_start, 0);
      chk("rst_end", burst_end, 0);
      chk("rst_len", burst_len, 0);
      chk("rst_trunc", burst_trunc, 0);
      chk("rst_I_out", I_out, 0);
      chk("rst_Q_out", Q_out, 0);
    end else begin
      chk("out_tvalid", out_tvalid, e_valid);
      if (e_valid) begin
        chk("I_out", I_out, e_i);
        chk("Q_out", Q_out, e_q);
      end
      chk("burst_active", burst_active, e_active);
      chk("burst_start", burst_start, e_start);
      chk("burst_end", burst_end, e_end);
      chk("burst_len", burst_len, e_len);
      chk("burst_trunc", burst_trunc, e_trunc);
      if (out_tvalid) begin cnt_valid++; k_valid = k; end
      if (out_tvalid && first_pend) begin first_out = I_out; first_pend = 1'b0; end
      if (burst_start) begin cnt_start++; k_start = k; in_at_start = I_tdata; first_pend = 1'b1; end
      if (burst_end) begin cnt_end++; k_end = k; end
      if (SD_flag && !prev_sd) k_rise = k;
      prev_sd = SD_flag;
      model_step();
    end
  end

  logic signed [15:0] ramp = 16'sd1;

  task automatic drive(input logic sd, input logic vi, input logic vq);
    @(posedge clk); #2;
    SD_flag = sd; I_tvalid = vi; Q_tvalid = vq;
    I_tdata = ramp; Q_tdata = ~ramp;
    ramp = ramp + 16'sd1;
  endtask

  task automatic run(input logic sd, input int n);
    repeat (n) drive(sd, 1'b1, 1'b1);
  endtask

  task automatic cfg(input int a, input int h, input int m);
    RX_BG_ARM = 8'(a); RX_BG_HANG = 8'(h); RX_BG_MAXLEN = 16'(m);
  endtask

  int s_start, s_end, s_valid;
  task automatic snap();
    s_start = cnt_start; s_end = cnt_end; s_valid = cnt_valid;
  endtask

  initial begin
    rst_n = 1'b0; SD_flag = 0; I_tvalid = 0; Q_tvalid = 0; I_tdata = 0; Q_tdata = 0;
    cfg(4, 3, 1000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run(0, 3);

    // Basic burst: 20 high, then low
    snap();
    run(1, 20); run(0, 10);
    chk("s1_starts", cnt_start - s_start, 1);
    chk("s1_start_delay", k_start - k_rise, 4);
    chk("s1_ends", cnt_end - s_end, 1);
    chk("s1_valids", cnt_valid - s_valid, 20);
    chk("s1_len", burst_len, 20);
    chk("s1_trunc", burst_trunc, 0);
    chk("s1_end_after_valid", k_end - k_valid, 1);
`ifdef RX_BG_PRETRIGGER_EN
    chk("s1_first_sample", first_out, in_at_start - 16'(PRE));
`else
    chk("s1_first_sample", first_out, in_at_start);
`endif

    // SD too short to arm
    snap();
    run(1, 3); run(0, 5);
    chk("s2_starts", cnt_start - s_start, 0);
    chk("s2_valids", cnt_valid - s_valid, 0);
    chk("s2_len_held", burst_len, 20);

    // Short dropout inside hang window
    snap();
    run(1, 12); run(0, 2); run(1, 8); run(0, 10);
    chk("s3_starts", cnt_start - s_start, 1);
    chk("s3_ends", cnt_end - s_end, 1);
    chk("s3_len", burst_len, 22);

    // Truncation at MAXLEN and lockout
    cfg(4, 3, 10);
    snap();
    run(1, 30);
    chk("s4_starts", cnt_start - s_start, 1);
    chk("s4_valids", cnt_valid - s_valid, 10);
    chk("s4_ends", cnt_end - s_end, 1);
    chk("s4_len", burst_len, 10);
    chk("s4_trunc", burst_trunc, 1);
    run(0, 3);
    snap();
    run(1, 8); run(0, 10);
    chk("s4b_starts", cnt_start - s_start, 1);
    chk("s4b_len", burst_len, 8);
    chk("s4b_trunc", burst_trunc, 0);

    // Zero arm/hang with gaps in sample_valid
    cfg(0, 0, 100);
    snap();
    for (int i = 0; i < 10; i++) drive(1'b1, (i % 3) != 0, (i % 2) == 0);
    run(0, 6);
    chk("s5_starts", cnt_start - s_start, 1);
    chk("s5_ends", cnt_end - s_end, 1);
    chk("s5_len", burst_len, 4);

    // MAXLEN of zero
    cfg(0, 3, 0);
    snap();
    run(1, 3); run(0, 5);
    chk("s6_starts", cnt_start - s_start, 1);
    chk("s6_ends", cnt_end - s_end, 1);
    chk("s6_valids", cnt_valid - s_valid, 0);
    chk("s6_len", burst_len, 0);
    chk("s6_trunc", burst_trunc, 1);

    // Config changes mid-burst are ignored
    cfg(2, 3, 1000);
    snap();
    run(1, 6);
    cfg(2, 0, 2);
    run(0, 2); run(1, 3); run(0, 8);
    chk("s7_starts", cnt_start - s_start, 1);
    chk("s7_ends", cnt_end - s_end, 1);
    chk("s7_len", burst_len, 13);
    chk("s7_trunc", burst_trunc, 0);

    // Reset in the middle of a burst
    cfg(2, 3, 1000);
    run(1, 8);
    snap();
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("s8_rst_tvalid", out_tvalid, 0);
    chk("s8_rst_active", burst_active, 0);
    run(1, 2);
    @(posedge clk); #2 rst_n = 1'b1; SD_flag = 1'b0;
    run(0, 4);
    chk("s8_no_end", cnt_end - s_end, 0);
    snap();
    run(1, 10); run(0, 8);
    chk("s8_starts", cnt_start - s_start, 1);
    chk("s8_ends", cnt_end - s_end, 1);
    chk("s8_len", burst_len, 12);

    run(0, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
